// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Producer side of the opcode interface feeding the main control decoder.
//   Keeps the program counter, fetches 32-bit instruction words over a
//   req/ack memory handshake, presents the decoded instruction fields with a
//   valid/ready handshake and resolves beq/bne redirects once the decoder's
//   Branch output and the ALU zero flag are available.
//
// Ports
//   i_clk             system clock, rising edge
//   i_rst             synchronous active-high reset
//   o_imem_req        fetch request, held until i_imem_ack
//   o_imem_addr       fetch address (the PC), stable while o_imem_req is high
//   i_imem_ack        one-cycle strobe, i_imem_rdata valid in that cycle
//   i_imem_rdata      fetched instruction word
//   o_instr_valid     instruction fields are valid
//   i_instr_ready     sink accepts the instruction (transfer = valid & ready)
//   o_opcode .. o_imm split fields of the held instruction
//   o_pc_plus4        address of the held instruction + 4
//   i_branch          decoder Branch output for the held opcode
//   i_alu_zero        ALU zero flag of the branch compare
//   i_branch_resolve  one-cycle strobe, i_branch / i_alu_zero valid
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [5:0]        o_opcode,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [5:0]        o_funct,
  output logic [15:0]       o_imm,
  output logic [ADDR_W-1:0] o_pc_plus4,
  input  logic              i_branch,
  input  logic              i_alu_zero,
  input  logic              i_branch_resolve
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [5:0]        OP_BEQ  = 6'b000100;
  localparam logic [5:0]        OP_BNE  = 6'b000101;

  typedef enum logic [1:0] {
    ST_RST_WAIT,
    ST_FETCH,
    ST_HOLD,
    ST_RESOLVE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [31:0]       r_ir;
  logic [31:0]       w_ir_next;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic [ADDR_W-1:0] w_pc_plus4_next;

  logic              w_is_beq;
  logic              w_is_bne;
  logic              w_taken;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_target;

  // Branch decode works on the held IR; the word offset is the 16-bit
  // immediate sign-extended and scaled by 4, added modulo 2^ADDR_W.
  assign w_is_beq = (r_ir[31:26] == OP_BEQ);
  assign w_is_bne = (r_ir[31:26] == OP_BNE);
  assign w_taken  = i_branch & ((w_is_beq & i_alu_zero) | (w_is_bne & ~i_alu_zero));
  assign w_offset = {{(ADDR_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_target = r_pc_plus4 + w_offset;

  // Fields are always driven from the IR, so they stay stable through HOLD
  // and RESOLVE and read as zero straight after reset.
  assign o_opcode    = r_ir[31:26];
  assign o_rs        = r_ir[25:21];
  assign o_rt        = r_ir[20:16];
  assign o_rd        = r_ir[15:11];
  assign o_shamt     = r_ir[10:6];
  assign o_funct     = r_ir[5:0];
  assign o_imm       = r_ir[15:0];
  assign o_imem_addr = r_pc;
  assign o_pc_plus4  = r_pc_plus4;

  // Next-state and handshake outputs. RST_WAIT spends one idle cycle with
  // the request low so a memory still working on a fetch from before reset
  // sees the request drop and aborts it.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_pc_plus4_next = r_pc_plus4;
    o_imem_req      = 1'b0;
    o_instr_valid   = 1'b0;
    case (r_state)
      ST_RST_WAIT: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_ir_next       = i_imem_rdata;
          w_pc_plus4_next = r_pc + PC_STEP;
          w_state_next    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_instr_ready) begin
          if (w_is_beq || w_is_bne) begin
            w_state_next = ST_RESOLVE;
          end else begin
            w_pc_next    = r_pc_plus4;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_RESOLVE: begin
        if (i_branch_resolve) begin
          w_pc_next    = w_taken ? w_target : r_pc_plus4;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_RST_WAIT;
      end
    endcase
  end

  // State register. Reset wins over everything, including an ack arriving
  // in the same cycle, so the IR is never loaded across a reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RST_WAIT;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_pc_plus4 <= RESET_PC + PC_STEP;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_pc_plus4 <= w_pc_plus4_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A small instruction ROM answers fetches
//   at the address the bench expects the PC to hold; every fetched word is
//   pushed to a scoreboard and popped when the instruction becomes valid.
//   A second instance with RESET_PC at the top of the address space covers
//   the PC wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pcPlus4;
  logic        branchIn;
  logic        aluZero;
  logic        branchResolve;

  logic        rst2;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic        imemAck2;
  logic [31:0] imemRdata2;
  logic        instrValid2;
  logic        instrReady2;
  logic [5:0]  opcode2;
  logic [4:0]  rs2, rt2, rd2, shamt2;
  logic [5:0]  funct2;
  logic [15:0] imm2;
  logic [31:0] pcPlus42;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } sbEntry_t;

  sbEntry_t    sb[$];
  sbEntry_t    ent;
  logic [31:0] modelPc;
  logic [31:0] heldAddr;
  logic [31:0] heldWord;
  int          testCount = 0;
  int          failCount = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imemReq), .o_imem_addr(imemAddr),
    .i_imem_ack(imemAck), .i_imem_rdata(imemRdata),
    .o_instr_valid(instrValid), .i_instr_ready(instrReady),
    .o_opcode(opcode), .o_rs(rs), .o_rt(rt), .o_rd(rd),
    .o_shamt(shamt), .o_funct(funct), .o_imm(imm), .o_pc_plus4(pcPlus4),
    .i_branch(branchIn), .i_alu_zero(aluZero), .i_branch_resolve(branchResolve)
  );

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .i_clk(clk), .i_rst(rst2),
    .o_imem_req(imemReq2), .o_imem_addr(imemAddr2),
    .i_imem_ack(imemAck2), .i_imem_rdata(imemRdata2),
    .o_instr_valid(instrValid2), .i_instr_ready(instrReady2),
    .o_opcode(opcode2), .o_rs(rs2), .o_rt(rt2), .o_rd(rd2),
    .o_shamt(shamt2), .o_funct(funct2), .o_imm(imm2), .o_pc_plus4(pcPlus42),
    .i_branch(1'b0), .i_alu_zero(1'b0), .i_branch_resolve(1'b0)
  );

  // Instruction ROM contents used by the directed program.
  function automatic logic [31:0] readMem(input logic [31:0] a);
    case (a)
      32'h00: return 32'h8C01_0004;
      32'h04: return 32'h2002_0005;
      32'h08: return 32'h0022_1820;
      32'h0C: return 32'h0043_2022;
      32'h10: return 32'h1000_FFFF;
      32'h14: return 32'h0800_0000;
      32'h18: return 32'hFC00_0000;
      32'h1C: return 32'h0000_0000;
      32'h20: return 32'h1400_0003;
      32'h30: return 32'h0000_0020;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Fetch at the model PC after lat idle cycles, then check the held fields.
  task automatic applyStimulus(input int lat);
    for (int i = 0; i < lat; i++) begin
      checkOutput("wait_req", 32'(imemReq), 32'd1);
      checkOutput("wait_addr", imemAddr, modelPc);
      checkOutput("wait_valid", 32'(instrValid), 32'd0);
      tick();
    end
    checkOutput("fetch_req", 32'(imemReq), 32'd1);
    checkOutput("fetch_addr", imemAddr, modelPc);
    imemAck   = 1'b1;
    imemRdata = readMem(modelPc);
    sb.push_back('{modelPc, imemRdata});
    tick();
    imemAck   = 1'b0;
    imemRdata = $urandom;
    ent       = sb.pop_front();
    heldAddr  = ent.addr;
    heldWord  = ent.word;
    checkOutput("hold_valid", 32'(instrValid), 32'd1);
    checkOutput("hold_req", 32'(imemReq), 32'd0);
    checkOutput("hold_fields", {opcode, rs, rt, rd, shamt, funct}, heldWord);
    checkOutput("hold_imm", 32'(imm), 32'(heldWord[15:0]));
    checkOutput("hold_pc_plus4", pcPlus4, heldAddr + 32'd4);
  endtask

  // Transfer the held instruction and check where the fetcher goes next.
  task automatic acceptInstr();
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
    checkOutput("accept_valid", 32'(instrValid), 32'd0);
    if (heldWord[31:26] == 6'b000100 || heldWord[31:26] == 6'b000101) begin
      checkOutput("resolve_req", 32'(imemReq), 32'd0);
      checkOutput("resolve_fields", {opcode, rs, rt, rd, shamt, funct}, heldWord);
    end else begin
      modelPc = heldAddr + 32'd4;
      checkOutput("next_req", 32'(imemReq), 32'd1);
      checkOutput("next_addr", imemAddr, modelPc);
    end
  endtask

  task automatic resolveBranch(input logic br, input logic z);
    logic beq, bne, taken;
    logic [31:0] off;
    beq   = (heldWord[31:26] == 6'b000100);
    bne   = (heldWord[31:26] == 6'b000101);
    taken = br & ((beq & z) | (bne & ~z));
    off   = {{14{heldWord[15]}}, heldWord[15:0], 2'b00};
    modelPc = taken ? heldAddr + 32'd4 + off : heldAddr + 32'd4;
    branchIn      = br;
    aluZero       = z;
    branchResolve = 1'b1;
    tick();
    branchResolve = 1'b0;
    checkOutput("branch_req", 32'(imemReq), 32'd1);
    checkOutput("branch_addr", imemAddr, modelPc);
  endtask

  task automatic checkReset();
    checkOutput("rst_req", 32'(imemReq), 32'd0);
    checkOutput("rst_valid", 32'(instrValid), 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
    checkOutput("rst_imm", 32'(imm), 32'h0);
    checkOutput("rst_pc_plus4", pcPlus4, 32'h4);
  endtask

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed program: each step drives stimulus and checks the response.
  initial begin
    rst = 1'b1; imemAck = 1'b0; imemRdata = 32'h0; instrReady = 1'b0;
    branchIn = 1'b0; aluZero = 1'b0; branchResolve = 1'b0;
    rst2 = 1'b1; imemAck2 = 1'b0; imemRdata2 = 32'h0; instrReady2 = 1'b0;
    tick();
    tick();
    checkReset();
    rst = 1'b0;
    modelPc = 32'h0;
    tick();

    // Zero-wait memory, sink always ready: one instruction every two cycles.
    applyStimulus(0);
    checkOutput("lw_opcode", 32'(opcode), 32'h23);
    acceptInstr();
    applyStimulus(0);
    checkOutput("addi_opcode", 32'(opcode), 32'h08);
    acceptInstr();

    // Reset lands on a FETCH cycle together with an ack: the word is dropped.
    rst = 1'b1; imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; imemAck = 1'b1; imemRdata = 32'hCAFE_F00D;
    checkReset();
    tick();
    imemAck = 1'b0;
    modelPc = 32'h0;
    checkOutput("rstwait_ack_valid", 32'(instrValid), 32'd0);
    checkOutput("rstwait_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);

    // Slow memory: request and address hold until the late ack.
    applyStimulus(3);
    acceptInstr();
    applyStimulus(1);
    acceptInstr();
    applyStimulus(0);
    acceptInstr();
    applyStimulus(2);
    acceptInstr();

    // beq at 0x10. A resolve strobe coinciding with the transfer is ignored.
    applyStimulus(0);
    instrReady = 1'b1; branchResolve = 1'b1; branchIn = 1'b1; aluZero = 1'b0;
    tick();
    instrReady = 1'b0; branchResolve = 1'b0;
    checkOutput("simul_req", 32'(imemReq), 32'd0);
    checkOutput("simul_valid", 32'(instrValid), 32'd0);
    imemAck = 1'b1; instrReady = 1'b1;
    tick();
    imemAck = 1'b0; instrReady = 1'b0;
    checkOutput("resolve_idle_req", 32'(imemReq), 32'd0);
    checkOutput("resolve_idle_fields", {opcode, rs, rt, rd, shamt, funct}, heldWord);
    resolveBranch(1'b1, 1'b1);
    applyStimulus(0);
    acceptInstr();
    resolveBranch(1'b1, 1'b0);

    // Jump and undefined opcodes simply advance the PC.
    applyStimulus(0);
    acceptInstr();
    applyStimulus(0);
    acceptInstr();
    applyStimulus(0);
    acceptInstr();

    // bne at 0x20 held for four cycles with stray strobes, then taken.
    applyStimulus(0);
    for (int i = 0; i < 4; i++) begin
      imemAck = (i == 1);
      imemRdata = 32'h1234_5678;
      branchResolve = (i == 2);
      tick();
      imemAck = 1'b0; branchResolve = 1'b0;
      checkOutput("stall_valid", 32'(instrValid), 32'd1);
      checkOutput("stall_req", 32'(imemReq), 32'd0);
      checkOutput("stall_fields", {opcode, rs, rt, rd, shamt, funct}, heldWord);
    end
    acceptInstr();
    resolveBranch(1'b1, 1'b0);
    applyStimulus(0);
    acceptInstr();

    // Wrap instance: PC starts at the last word of the address space.
    tick();
    checkOutput("wrap_rst_addr", imemAddr2, 32'hFFFF_FFFC);
    checkOutput("wrap_rst_pc_plus4", pcPlus42, 32'h0);
    rst2 = 1'b0;
    tick();
    checkOutput("wrap_fetch_req", 32'(imemReq2), 32'd1);
    checkOutput("wrap_fetch_addr", imemAddr2, 32'hFFFF_FFFC);
    imemAck2 = 1'b1;
    imemRdata2 = 32'h2002_0005;
    sb.push_back('{32'hFFFF_FFFC, imemRdata2});
    tick();
    imemAck2 = 1'b0;
    ent = sb.pop_front();
    checkOutput("wrap_valid", 32'(instrValid2), 32'd1);
    checkOutput("wrap_fields", {opcode2, rs2, rt2, rd2, shamt2, funct2}, ent.word);
    checkOutput("wrap_pc_plus4", pcPlus42, ent.addr + 32'd4);
    instrReady2 = 1'b1;
    tick();
    instrReady2 = 1'b0;
    checkOutput("wrap_next_req", 32'(imemReq2), 32'd1);
    checkOutput("wrap_next_addr", imemAddr2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
